// File: rtl/apu_frame_sequencer.sv
// apu_frame_sequencer: $4017 frame counter producing quarter/half-frame ticks and the frame IRQ
module apu_frame_sequencer #(
  parameter int unsigned STEP1 = 7457,
  parameter int unsigned STEP2 = 14913,
  parameter int unsigned STEP3 = 22371,
  parameter int unsigned STEP4 = 29829,
  parameter int unsigned STEP5 = 37281
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_ce,
  input  logic       wr_4017,
  input  logic [7:0] wr_data,
  input  logic       rd_4015,
  output logic       quarter_tick,
  output logic       half_tick,
  output logic       irq,
  output logic       frame_mode
);
  localparam logic [15:0] S1 = 16'(STEP1);
  localparam logic [15:0] S2 = 16'(STEP2);
  localparam logic [15:0] S3 = 16'(STEP3);
  localparam logic [15:0] S4 = 16'(STEP4);
  localparam logic [15:0] S5 = 16'(STEP5);
  logic [15:0] cnt_q, cnt_d;
  logic mode_q, mode_d, inh_q, inh_d, irq_q, irq_d, pend_q, pend_d, qt_q, qt_d, ht_q, ht_d;
  logic adv, restart, step_ok, last, fin, set_irq;
  always_comb begin
    adv     = cpu_ce & ~pend_q;
    restart = cpu_ce & pend_q & ~wr_4017;
    last    = mode_q ? (cnt_q == S5) : (cnt_q == S4);
    cnt_d   = restart ? 16'd0 : adv ? (last ? 16'd0 : cnt_q + 16'd1) : cnt_q;
    // a write landing on an event clk suppresses that step; the restart follows on the next ce
    step_ok = adv & ~wr_4017;
    fin     = mode_q ? (cnt_d == S5) : (cnt_d == S4);
    qt_d    = restart ? mode_q : step_ok & ((cnt_d == S1) | (cnt_d == S2) | (cnt_d == S3) | fin);
    ht_d    = restart ? mode_q : step_ok & ((cnt_d == S2) | fin);
    set_irq = step_ok & ~mode_q & ~inh_q & (cnt_d == S4);
    irq_d   = (wr_4017 & wr_data[6]) ? 1'b0 : set_irq ? 1'b1 : rd_4015 ? 1'b0 : irq_q;
    mode_d  = wr_4017 ? wr_data[7] : mode_q;
    inh_d   = wr_4017 ? wr_data[6] : inh_q;
    pend_d  = wr_4017 | (pend_q & ~restart);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      mode_q <= 1'b0;
      inh_q  <= 1'b0;
      irq_q  <= 1'b0;
      pend_q <= 1'b0;
      qt_q   <= 1'b0;
      ht_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
      inh_q  <= inh_d;
      irq_q  <= irq_d;
      pend_q <= pend_d;
      qt_q   <= qt_d;
      ht_q   <= ht_d;
    end
  end
  assign quarter_tick = qt_q;
  assign half_tick    = ht_q;
  assign irq          = irq_q;
  assign frame_mode   = mode_q;
endmodule

// File: doc/apu_frame_sequencer.md
# apu_frame_sequencer

Frame sequencer for the PAPU: divides the CPU-cycle strobe into the quarter-frame and half-frame ticks that clock the envelope, linear, length-counter and sweep units. It also implements the $4017 frame-counter register with 4-step and 5-step modes. It generates and clears the frame IRQ flag reported through $4015. It sits between the CPU register bus decode and the per-channel units, replacing their free-running 29830-cycle dividers with one shared, software-resettable schedule.

## Interface
Parameters:
- STEP1, default 7457: cycle-counter value of step 1.
- STEP2, default 14913: cycle-counter value of step 2.
- STEP3, default 22371: cycle-counter value of step 3.
- STEP4, default 29829: cycle-counter value of step 4; last step in 4-step mode (period 29830).
- STEP5, default 37281: cycle-counter value of step 5; last step in 5-step mode (period 37282).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cpu_ce  in  1  one-clk strobe, once per CPU cycle.
- wr_4017  in  1  one-clk write strobe for $4017.
- wr_data  in  8  write data; bit7 = mode (1 = 5-step), bit6 = IRQ inhibit.
- rd_4015  in  1  one-clk strobe for a $4015 read; clears the frame IRQ.
- quarter_tick  out  1  one-clk pulse that clocks envelopes and the triangle linear counter.
- half_tick  out  1  one-clk pulse that clocks length counters and sweeps.
- irq  out  1  frame IRQ flag (level).
- frame_mode  out  1  current mode bit.

## Operation
- State: cycle_cnt[15:0], mode, inhibit, irq_flag, pend (write pending), registered tick outputs.
- Counting: on each clk with cpu_ce=1 and pend=0, cycle_cnt advances to next value.
  - next = 0 if (mode=0 and cycle_cnt=STEP4) or (mode=1 and cycle_cnt=STEP5).
  - Otherwise next = cycle_cnt+1.
  - No other wrap.
- Step events evaluate on the next value only:
  - 4-step mode:
    - quarter at STEP1..STEP4.
    - half at STEP2 and STEP4.
    - irq_flag set at STEP4 when inhibit=0.
  - 5-step mode:
    - quarter at STEP1, STEP2, STEP3, STEP5.
    - half at STEP2 and STEP5.
    - Nothing at STEP4 (counter passes through it).
    - Never sets IRQ.
- Write to $4017:
  - On the wr_4017 clk, mode<=wr_data[7] and inhibit<=wr_data[6].
  - If wr_data[6]=1, irq_flag<=0.
  - pend<=1.
  - A second write while pend=1 overwrites mode/inhibit; pend stays 1.
- Pending reset:
  - On the first clk with cpu_ce=1 and pend=1 (not the write clk itself), cycle_cnt<=0 and pend<=0.
  - If mode=1 at that moment, quarter_tick and half_tick fire once.
  - No step event is evaluated that cycle.
- IRQ clear:
  - rd_4015 clears irq_flag.
  - inhibit=1 holds irq_flag at 0.
- Priority within one clk:
  - reset > irq set > rd_4015 clear.
  - The exception: a $4017 write with bit6=1 clears irq_flag even on a set cycle.
  - A pending reset beats a step event.

## Timing
- Reset values: all outputs 0; cycle_cnt=0, mode=0, inhibit=0, pend=0.
- Reset mid-frame discards any pending write and restarts the 4-step schedule from 0 with no tick.
- Ticks are registered:
  - They are high for exactly the one clk following the cpu_ce clk that produced the event.
  - They are never high two consecutive clks.
  - quarter and half are coincident whenever both fire.
- irq and frame_mode are registered: they update one clk after the causing edge and hold until changed.
- Write-to-restart latency: the counter reads 0 after the first cpu_ce strictly after the write clk. The immediate 5-step ticks appear one clk later.
- cpu_ce=0 freezes cycle_cnt and pend; writes and reads still take effect.

## Test plan
Bench parameters: STEP1=4, STEP2=8, STEP3=12, STEP4=16, STEP5=20; cpu_ce tied 1 unless stated.
- 4-step free run from reset:
  - quarter pulses one clk after counts 4, 8, 12, 16.
  - half after 8 and 16.
  - irq rises after 16.
  - Period is 17 ce.
  - irq stays 1 across wraps until rd_4015, then 0 next clk.
- Write 0x80:
  - frame_mode=1.
  - Counter resets on the next ce, with quarter+half pulses one clk after that.
  - Then quarter at 4, 8, 12, 20 and half at 8, 20.
  - No pulse at 16; irq never rises; period 21.
- Write 0x40 while irq=1: irq=0 next clk and stays 0 through several 4-step periods. Write 0x00: irq rises again at the next count 16.
- Simultaneous events:
  - rd_4015 on the same clk irq would be set: irq=1.
  - Write 0x00 on the clk the counter reaches 16: counter goes to 0 next ce; the STEP4 tick and irq set are suppressed.
- cpu_ce gated to 1-in-3 clks: event spacing in ce counts unchanged; pending write waits for the next ce; ticks still exactly one clk wide.
- Assert reset at count 10 in 5-step mode with pend=1:
  - All outputs 0 and mode=0.
  - Following run matches the 4-step schedule from 0 with no immediate tick.
